// File: rtl/netfpga_if_line_packer.sv
// netfpga_if_line_packer: packs 64-bit netfpga_if words into 256-bit lines,
// one worker_id per line, and pushes them into an Avalon write-master user
// buffer. Optional idle auto-flush is enabled by defining LINE_PACKER_TIMEOUT_EN.
module netfpga_if_line_packer #(
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    ID_WIDTH      = 8,
  parameter int                    LINE_WIDTH    = 256,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD      = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int                    FLUSH_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ID_WIDTH-1:0]   worker_id,
  output logic                  rdy,
  input  logic                  flush,
  output logic                  wr_done,
  output logic                  user_write_buffer,
  output logic [LINE_WIDTH-1:0] user_buffer_data,
  input  logic                  user_buffer_full,
  output logic [31:0]           lines_written
);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_PUSH = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [ID_WIDTH-1:0]   hold_id_q, hold_id_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  rdy_q, rdy_d;
  logic                  wr_done_q, wr_done_d;
  logic [31:0]           lines_q, lines_d;
  logic                  accept;
  logic                  pend;
  logic [2:0]            cnt_n;
`ifdef LINE_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  logic [TW-1:0]         tmo_q, tmo_d;
`endif

  // Fill every slot from index n upward with the pad word.
  function automatic logic [LINE_WIDTH-1:0] pad_line(input logic [LINE_WIDTH-1:0] l,
                                                     input logic [2:0] n);
    logic [LINE_WIDTH-1:0] r;
    r = l;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) >= n) r[k*DATA_WIDTH +: DATA_WIDTH] = PAD_WORD;
    end
    return r;
  endfunction

  assign accept            = wr && rdy_q;
  assign user_write_buffer = (state_q == S_PUSH) && !user_buffer_full;
  assign user_buffer_data  = line_q;
  assign rdy               = rdy_q;
  assign wr_done           = wr_done_q;
  assign lines_written     = lines_q;

  // Next-state logic: slot packing, id-change hold, flush handling and push.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    cur_id_d     = cur_id_q;
    hold_d       = hold_q;
    hold_id_d    = hold_id_q;
    hold_valid_d = hold_valid_q;
    flush_pend_d = flush_pend_q;
    wr_done_d    = 1'b0;
    lines_d      = lines_q;
    pend         = flush_pend_q | flush;
    cnt_n        = cnt_q;
`ifdef LINE_PACKER_TIMEOUT_EN
    tmo_d        = '0;
`endif
    case (state_q)
      S_FILL: begin
        if (accept) begin
          if (cnt_q != 3'd0 && worker_id != cur_id_q) begin
            // Word belongs to another worker: park it, close the current line.
            hold_d       = data;
            hold_id_d    = worker_id;
            hold_valid_d = 1'b1;
            line_d       = pad_line(line_q, cnt_q);
            state_d      = S_PUSH;
          end else begin
            line_d[cnt_q[1:0]*DATA_WIDTH +: DATA_WIDTH] = data;
            if (cnt_q == 3'd0) cur_id_d = worker_id;
            cnt_n = cnt_q + 3'd1;
            cnt_d = cnt_n;
            if (cnt_n == 3'd4) state_d = S_PUSH;
          end
        end
        if (flush) begin
          flush_pend_d = 1'b1;
          if (state_d == S_FILL) begin
            if (cnt_n != 3'd0) begin
              line_d  = pad_line(line_d, cnt_n);
              state_d = S_PUSH;
            end else begin
              wr_done_d    = 1'b1;
              flush_pend_d = 1'b0;
            end
          end
        end
`ifdef LINE_PACKER_TIMEOUT_EN
        else if (state_d == S_FILL && cnt_q != 3'd0 && !accept) begin
          // Idle partial line: push it like a flush, without wr_done.
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(FLUSH_TIMEOUT)) begin
            line_d  = pad_line(line_q, cnt_q);
            state_d = S_PUSH;
            tmo_d   = '0;
          end
        end
`endif
      end
      default: begin
        flush_pend_d = pend;
        if (user_write_buffer) begin
          lines_d = lines_q + 32'd1;
          cnt_d   = 3'd0;
          state_d = S_FILL;
          if (hold_valid_q) begin
            line_d[DATA_WIDTH-1:0] = hold_q;
            cur_id_d     = hold_id_q;
            cnt_d        = 3'd1;
            hold_valid_d = 1'b0;
          end
          if (pend) begin
            if (hold_valid_q) begin
              // Flush must also drain the line started by the held word.
              line_d  = pad_line(line_d, 3'd1);
              state_d = S_PUSH;
            end else begin
              wr_done_d    = 1'b1;
              flush_pend_d = 1'b0;
            end
          end
        end
      end
    endcase
    rdy_d = (state_d == S_FILL) && !hold_valid_d;
  end

  // Control state and the visible line register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_FILL;
      cnt_q        <= 3'd0;
      line_q       <= '0;
      hold_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      rdy_q        <= 1'b0;
      wr_done_q    <= 1'b0;
      lines_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      hold_valid_q <= hold_valid_d;
      flush_pend_q <= flush_pend_d;
      rdy_q        <= rdy_d;
      wr_done_q    <= wr_done_d;
      lines_q      <= lines_d;
    end
  end

  // Payload-only registers; their contents are qualified by cnt/hold_valid.
  always_ff @(posedge clk) begin
    cur_id_q  <= cur_id_d;
    hold_q    <= hold_d;
    hold_id_q <= hold_id_d;
  end

`ifdef LINE_PACKER_TIMEOUT_EN
  // Idle cycle counter for the auto-flush of partial lines.
  always_ff @(posedge clk) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_netfpga_if_line_packer.sv
// Bench for netfpga_if_line_packer: table of packing scenarios with a line
// scoreboard, plus hand sequences for reset, latency, backpressure and flush.
module tb_netfpga_if_line_packer;

  localparam logic [63:0] P = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         wr = 1'b0;
  logic [63:0]  data = '0;
  logic [7:0]   worker_id = '0;
  logic         rdy;
  logic         flush = 1'b0;
  logic         wr_done;
  logic         user_write_buffer;
  logic [255:0] user_buffer_data;
  logic         user_buffer_full = 1'b0;
  logic [31:0]  lines_written;

  netfpga_if_line_packer dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .data(data), .worker_id(worker_id),
    .rdy(rdy), .flush(flush), .wr_done(wr_done),
    .user_write_buffer(user_write_buffer), .user_buffer_data(user_buffer_data),
    .user_buffer_full(user_buffer_full), .lines_written(lines_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [3:0][7:0]  id;
    logic [3:0][63:0] d;
    bit               fl;
    int               nl;
    logic [255:0]     l0;
    logic [255:0]     l1;
    int               nwd;
  } vec_t;

  int           nvec = 0;
  int           nfail = 0;
  int           wd_cnt = 0;
  logic [255:0] exp_q[$];
  vec_t         vt[5];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [3:0][7:0] id,
                              input logic [3:0][63:0] d, input bit fl, input int nl,
                              input logic [255:0] l0, input logic [255:0] l1, input int nwd);
    vec_t v;
    v.n = n; v.id = id; v.d = d; v.fl = fl; v.nl = nl; v.l0 = l0; v.l1 = l1; v.nwd = nwd;
    return v;
  endfunction

  // Line scoreboard and wr_done pulse counter.
  always @(negedge clk) begin
    if (reset_n && user_write_buffer) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_push: got %0h required no push", user_buffer_data);
      end else begin
        chk("line", user_buffer_data, exp_q.pop_front());
      end
    end
    if (reset_n && wr_done) wd_cnt++;
  end

  // Present one word and hold it until it is accepted on a rising edge.
  task automatic send(input logic [7:0] id, input logic [63:0] d);
    int t;
    t = 0;
    @(negedge clk);
    wr = 1'b1; worker_id = id; data = d;
    while (!rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      nvec++; nfail++;
      $display("FAIL send_timeout: got rdy=0 required rdy=1 within 200 cycles");
    end
    @(posedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk);
    wr = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    wr = 1'b0;
    while (exp_q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("drained", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    int lw_exp;
    int wd0;
    logic [255:0] lbp;

    vt[0] = mk(4, {8'd3, 8'd3, 8'd3, 8'd3}, {64'd4, 64'd3, 64'd2, 64'd1}, 0, 1,
               {64'd4, 64'd3, 64'd2, 64'd1}, '0, 0);
    vt[1] = mk(3, {8'd0, 8'd2, 8'd1, 8'd1}, {64'd0, 64'hC, 64'hB, 64'hA}, 1, 2,
               {P, P, 64'hB, 64'hA}, {P, P, P, 64'hC}, 1);
    vt[2] = mk(4, {8'd6, 8'd6, 8'd5, 8'd5}, {64'd13, 64'd12, 64'd11, 64'd10}, 1, 2,
               {P, P, 64'd11, 64'd10}, {P, P, 64'd13, 64'd12}, 1);
    vt[3] = mk(1, {8'd0, 8'd0, 8'd0, 8'd9}, {64'd0, 64'd0, 64'd0, 64'h99}, 1, 1,
               {P, P, P, 64'h99}, '0, 1);
    vt[4] = mk(4, {8'd7, 8'd7, 8'd7, 8'd7}, {64'h73, 64'h72, 64'h71, 64'h70}, 1, 1,
               {64'h73, 64'h72, 64'h71, 64'h70}, '0, 1);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rdy", 256'(rdy), 256'd0);
    chk("rst_wr_done", 256'(wr_done), 256'd0);
    chk("rst_uwb", 256'(user_write_buffer), 256'd0);
    chk("rst_data", user_buffer_data, 256'd0);
    chk("rst_lines", 256'(lines_written), 256'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 256'(rdy), 256'd1);
    lw_exp = 0;

    // Full line: push one cycle after 4th accept, rdy low exactly one cycle
    exp_q.push_back({64'd4, 64'd3, 64'd2, 64'd1});
    for (int i = 1; i <= 4; i++) send(8'd3, 64'(i));
    @(negedge clk);
    wr = 1'b0;
    chk("lat_uwb", 256'(user_write_buffer), 256'd1);
    chk("lat_rdy_low", 256'(rdy), 256'd0);
    @(negedge clk);
    chk("lat_rdy_back", 256'(rdy), 256'd1);
    chk("lat_uwb_off", 256'(user_write_buffer), 256'd0);
    lw_exp++;
    chk("lat_lines", 256'(lines_written), 256'(lw_exp));

    // Table of packing scenarios
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vt[v].l0);
      if (vt[v].nl > 1) exp_q.push_back(vt[v].l1);
      lw_exp += vt[v].nl;
      wd0 = wd_cnt;
      for (int w = 0; w < vt[v].n; w++) send(vt[v].id[w], vt[v].d[w]);
      if (vt[v].fl) do_flush();
      drain();
      chk("tbl_lines", 256'(lines_written), 256'(lw_exp));
      chk("tbl_wr_done", 256'(wd_cnt - wd0), 256'(vt[v].nwd));
    end

    // Backpressure: line held stable while the buffer is full
    lbp = {64'h23, 64'h22, 64'h21, 64'h20};
    @(negedge clk);
    user_buffer_full = 1'b1;
    exp_q.push_back(lbp);
    for (int i = 0; i < 4; i++) send(8'd2, 64'h20 + 64'(i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      wr = 1'b0;
      chk("bp_uwb_low", 256'(user_write_buffer), 256'd0);
      chk("bp_data", user_buffer_data, lbp);
      chk("bp_rdy_low", 256'(rdy), 256'd0);
    end
    @(posedge clk);
    #1 user_buffer_full = 1'b0;
    @(negedge clk);
    chk("bp_uwb_high", 256'(user_write_buffer), 256'd1);
    @(negedge clk);
    chk("bp_rdy_back", 256'(rdy), 256'd1);
    lw_exp++;
    chk("bp_lines", 256'(lines_written), 256'(lw_exp));

    // Flush while idle with an empty line
    wd0 = wd_cnt;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("idle_wr_done", 256'(wr_done), 256'd1);
    chk("idle_uwb", 256'(user_write_buffer), 256'd0);
    @(negedge clk);
    chk("idle_wr_done_off", 256'(wr_done), 256'd0);
    chk("idle_lines", 256'(lines_written), 256'(lw_exp));
    chk("idle_pulses", 256'(wd_cnt - wd0), 256'd1);

    // Reset with two words buffered: they must never appear
    send(8'd4, 64'hDEAD);
    send(8'd4, 64'hBEEF);
    @(negedge clk);
    wr = 1'b0; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_lines", 256'(lines_written), 256'd0);
    chk("mid_rst_data", user_buffer_data, 256'd0);
    chk("mid_rst_rdy", 256'(rdy), 256'd0);
    reset_n = 1'b1;
    lw_exp = 0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_push", 256'(lines_written), 256'd0);
    exp_q.push_back({64'h43, 64'h42, 64'h41, 64'h40});
    for (int i = 0; i < 4; i++) send(8'd4, 64'h40 + 64'(i));
    drain();
    chk("mid_rst_clean_lines", 256'(lines_written), 256'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish required finish within 400000");
    $fatal(1);
  end

endmodule
